// File: rtl/sfp_acc_ctrl.sv
// sfp_acc_ctrl: per-tile sequencer popping ofifo rows and issuing aligned pmsm read / SFP / write-back controls.
// Optional define SFP_CTRL_PERF_EN adds the stall_cnt performance counter output.
module sfp_acc_ctrl #(
  parameter int addr_w = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w:0]   num_rows,
  input  logic [addr_w-1:0] base_addr,
  input  logic              acc_en,
  input  logic              relu_en,
  input  logic              ofifo_valid,
  output logic              ofifo_rd,
  output logic              pmsm_rd,
  output logic [addr_w-1:0] pmsm_rd_addr,
  output logic              pmsm_wr,
  output logic [addr_w-1:0] pmsm_wr_addr,
  output logic              zero_pmsm,
  output logic              en_relu,
  output logic              busy,
  output logic              done
`ifdef SFP_CTRL_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [addr_w:0]   MAX_ROWS = {1'b1, {addr_w{1'b0}}};
  localparam logic [addr_w:0]   ONE_ROW  = {{addr_w{1'b0}}, 1'b1};
  localparam logic [addr_w:0]   NO_ROWS  = {(addr_w + 1){1'b0}};
  localparam logic [addr_w-1:0] ZERO_A   = {addr_w{1'b0}};
  localparam logic [addr_w-1:0] ONE_A    = {{(addr_w - 1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [addr_w:0]   remaining_r;
  logic [addr_w-1:0] next_addr_r;
  logic              acc_cfg_r;
  logic              en_relu_r;
  logic              busy_r;
  logic              done_r;
  logic [2:0]        vld_r;
  logic [addr_w-1:0] addr_r [3];
  logic              pmsm_rd_r;
  logic              zero_pmsm_r;
  logic [addr_w:0]   rows_clamped_s;
  logic              accept_s;

  assign rows_clamped_s = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
  assign accept_s       = (state_r == RUN) && ofifo_valid && (remaining_r != NO_ROWS);

  // Pass FSM: latches config on start, counts accepted rows, waits for the pipeline to drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      remaining_r <= NO_ROWS;
      next_addr_r <= ZERO_A;
      acc_cfg_r   <= 1'b0;
      en_relu_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            acc_cfg_r   <= acc_en;
            next_addr_r <= base_addr;
            remaining_r <= rows_clamped_s;
            if (num_rows != NO_ROWS) begin
              state_r   <= RUN;
              busy_r    <= 1'b1;
              en_relu_r <= relu_en;
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept_s) begin
            remaining_r <= remaining_r - ONE_ROW;
            next_addr_r <= next_addr_r + ONE_A;
            if (remaining_r == ONE_ROW) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Only the write stage left in flight: it retires this edge, so done lands right after it.
          if (vld_r[1:0] == 2'b00) begin
            state_r   <= DONE;
            busy_r    <= 1'b0;
            en_relu_r <= 1'b0;
            done_r    <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          en_relu_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  // Row pipeline: valid/tag shift register aligning pmsm read, SFP zero-select and write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_r       <= 3'b000;
      addr_r[0]   <= ZERO_A;
      addr_r[1]   <= ZERO_A;
      addr_r[2]   <= ZERO_A;
      pmsm_rd_r   <= 1'b0;
      zero_pmsm_r <= 1'b0;
    end else begin
      vld_r       <= {vld_r[1:0], accept_s};
      addr_r[0]   <= next_addr_r;
      addr_r[1]   <= addr_r[0];
      addr_r[2]   <= addr_r[1];
      pmsm_rd_r   <= accept_s & acc_cfg_r;
      zero_pmsm_r <= vld_r[0] & ~acc_cfg_r;
    end
  end

  assign ofifo_rd     = accept_s;
  assign pmsm_rd      = pmsm_rd_r;
  assign pmsm_rd_addr = addr_r[0];
  assign zero_pmsm    = zero_pmsm_r;
  assign pmsm_wr      = vld_r[2];
  assign pmsm_wr_addr = addr_r[2];
  assign en_relu      = en_relu_r;
  assign busy         = busy_r;
  assign done         = done_r;

`ifdef SFP_CTRL_PERF_EN
  logic [15:0] stall_cnt_r;

  // Stall counter: RUN cycles starved by an empty ofifo, saturating, held after done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == IDLE) && start) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == RUN) && (remaining_r != NO_ROWS) && !ofifo_valid &&
                 (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_sfp_acc_ctrl.sv
// Self-checking bench for sfp_acc_ctrl: per-pass scoreboard of expected accepts, reads, zero-selects and writes.
module tb_sfp_acc_ctrl;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_rows;
  logic [AW-1:0] base_addr;
  logic          acc_en;
  logic          relu_en;
  logic          ofifo_valid;
  logic          ofifo_rd;
  logic          pmsm_rd;
  logic [AW-1:0] pmsm_rd_addr;
  logic          pmsm_wr;
  logic [AW-1:0] pmsm_wr_addr;
  logic          zero_pmsm;
  logic          en_relu;
  logic          busy;
  logic          done;
`ifdef SFP_CTRL_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } ev_t;

  sfp_acc_ctrl #(.addr_w(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .base_addr(base_addr),
    .acc_en(acc_en), .relu_en(relu_en), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
    .pmsm_rd(pmsm_rd), .pmsm_rd_addr(pmsm_rd_addr), .pmsm_wr(pmsm_wr),
    .pmsm_wr_addr(pmsm_wr_addr), .zero_pmsm(zero_pmsm), .en_relu(en_relu),
    .busy(busy), .done(done)
`ifdef SFP_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic vbit(input logic [31:0] m, input int c);
    if (c >= 0 && c < 32) return m[c];
    else return 1'b1;
  endfunction

  // Runs one pass; cycle 0 is the start cycle. spur_c injects an extra (to be ignored) start.
  task automatic run_pass(input string name, input int rows, input logic [AW-1:0] base,
                          input logic acc, input logic relu, input logic [31:0] vmask,
                          input int spur_c);
    ev_t rd_q[$];
    ev_t wr_q[$];
    int  acc_q[$];
    int  zr_q[$];
    ev_t ev;
    int  rem, last, stalls, end_c;
    logic [AW-1:0] tag;
    logic e_acc, e_rd, e_wr, e_zr, e_busy, e_done, e_relu;
    logic [AW-1:0] e_rd_addr, e_wr_addr;

    rem = (rows > (1 << AW)) ? (1 << AW) : rows;
    last = 0; stalls = 0; tag = base;
    for (int c = 1; rem > 0 && c < 1000; c++) begin
      if (vbit(vmask, c)) begin
        acc_q.push_back(c);
        ev.cyc = c + 1; ev.addr = tag;
        if (acc) rd_q.push_back(ev);
        else zr_q.push_back(c + 2);
        ev.cyc = c + 3;
        wr_q.push_back(ev);
        tag = tag + 1'b1; rem--; last = c;
      end else begin
        stalls++;
      end
    end
    end_c = (rows == 0) ? 3 : last + 6;

    for (int c = 0; c <= end_c; c++) begin
      start       = (c == 0) || (c == spur_c);
      num_rows    = (c == 0) ? rows[AW:0] : 8'd0;
      base_addr   = (c == 0) ? base : 7'h55;
      acc_en      = (c == 0) ? acc : ~acc;
      relu_en     = (c == 0) ? relu : ~relu;
      ofifo_valid = vbit(vmask, c);
      @(negedge clk);

      e_acc = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_zr = 1'b0;
      e_rd_addr = 7'd0; e_wr_addr = 7'd0;
      if (acc_q.size() > 0) if (acc_q[0] == c) begin e_acc = 1'b1; void'(acc_q.pop_front()); end
      if (rd_q.size() > 0) if (rd_q[0].cyc == c) begin
        e_rd = 1'b1; ev = rd_q.pop_front(); e_rd_addr = ev.addr;
      end
      if (zr_q.size() > 0) if (zr_q[0] == c) begin e_zr = 1'b1; void'(zr_q.pop_front()); end
      if (wr_q.size() > 0) if (wr_q[0].cyc == c) begin
        e_wr = 1'b1; ev = wr_q.pop_front(); e_wr_addr = ev.addr;
      end
      e_busy = (rows != 0) && (c >= 1) && (c <= last + 3);
      e_done = (rows == 0) ? (c == 1) : (c == last + 4);
      e_relu = e_busy && relu;

      checks += 7;
      if (ofifo_rd !== e_acc) begin errors++; $display("FAIL %s c%0d ofifo_rd got=%b exp=%b", name, c, ofifo_rd, e_acc); end
      if (pmsm_rd !== e_rd) begin errors++; $display("FAIL %s c%0d pmsm_rd got=%b exp=%b", name, c, pmsm_rd, e_rd); end
      if (zero_pmsm !== e_zr) begin errors++; $display("FAIL %s c%0d zero_pmsm got=%b exp=%b", name, c, zero_pmsm, e_zr); end
      if (pmsm_wr !== e_wr) begin errors++; $display("FAIL %s c%0d pmsm_wr got=%b exp=%b", name, c, pmsm_wr, e_wr); end
      if (busy !== e_busy) begin errors++; $display("FAIL %s c%0d busy got=%b exp=%b", name, c, busy, e_busy); end
      if (done !== e_done) begin errors++; $display("FAIL %s c%0d done got=%b exp=%b", name, c, done, e_done); end
      if (en_relu !== e_relu) begin errors++; $display("FAIL %s c%0d en_relu got=%b exp=%b", name, c, en_relu, e_relu); end
      if (e_rd) begin
        checks++;
        if (pmsm_rd_addr !== e_rd_addr) begin errors++; $display("FAIL %s c%0d rd_addr got=%0d exp=%0d", name, c, pmsm_rd_addr, e_rd_addr); end
      end
      if (e_wr) begin
        checks++;
        if (pmsm_wr_addr !== e_wr_addr) begin errors++; $display("FAIL %s c%0d wr_addr got=%0d exp=%0d", name, c, pmsm_wr_addr, e_wr_addr); end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; num_rows = 8'd0; ofifo_valid = 1'b0;

    checks++;
    if (acc_q.size() + rd_q.size() + zr_q.size() + wr_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover events got=%0d exp=0", name, acc_q.size() + rd_q.size() + zr_q.size() + wr_q.size());
    end
`ifdef SFP_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== stalls[15:0]) begin errors++; $display("FAIL %s stall_cnt got=%0d exp=%0d", name, stall_cnt, stalls); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_rows = 8'd0; base_addr = 7'd0;
    acc_en = 1'b0; relu_en = 1'b0; ofifo_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ofifo_rd, pmsm_rd, pmsm_wr, zero_pmsm, en_relu, busy, done, pmsm_rd_addr, pmsm_wr_addr} !== 21'd0) begin
      errors++; $display("FAIL reset outputs got=%h exp=0", {ofifo_rd, pmsm_rd, pmsm_wr, zero_pmsm, en_relu, busy, done, pmsm_rd_addr, pmsm_wr_addr});
    end
`ifdef SFP_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();       run_pass("basic", 4, 7'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, -1); endtask
  task automatic test_first_pass();  run_pass("first_pass", 3, 7'd5, 1'b0, 1'b1, 32'hFFFF_FFFF, -1); endtask
  task automatic test_bubbles();     run_pass("bubbles", 3, 7'd0, 1'b1, 1'b0, ~32'h0000_000C, -1); endtask
  task automatic test_wrap();        run_pass("wrap", 4, 7'd126, 1'b1, 1'b1, 32'hFFFF_FFFF, -1); endtask
  task automatic test_zero_rows();   run_pass("zero_rows", 0, 7'd9, 1'b1, 1'b1, 32'hFFFF_FFFF, -1); endtask
  task automatic test_start_ignored(); run_pass("start_ignored", 4, 7'd10, 1'b1, 1'b0, 32'hFFFF_FFFF, 2); endtask
  task automatic test_clamp();       run_pass("clamp", 200, 7'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, -1); endtask

  task automatic test_back_to_back();
    run_pass("b2b_a", 2, 7'd40, 1'b1, 1'b1, 32'hFFFF_FFF5, -1);
    run_pass("b2b_b", 5, 7'd60, 1'b0, 1'b0, 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_reset_mid_pass();
    for (int c = 0; c <= 9; c++) begin
      start       = (c == 0);
      num_rows    = 8'd4;
      base_addr   = 7'd20;
      acc_en      = 1'b1;
      relu_en     = 1'b1;
      ofifo_valid = 1'b1;
      if (c == 3) reset = 1'b1;
      if (c == 5) reset = 1'b0;
      @(negedge clk);
      if (c >= 3) begin
        checks++;
        if ({ofifo_rd, pmsm_rd, pmsm_wr, zero_pmsm, en_relu, busy, done} !== 7'd0) begin
          errors++; $display("FAIL reset_mid c%0d outputs got=%b exp=0", c, {ofifo_rd, pmsm_rd, pmsm_wr, zero_pmsm, en_relu, busy, done});
        end
      end else if (c >= 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid c%0d busy got=%b exp=1", c, busy); end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; ofifo_valid = 1'b0;
    run_pass("after_reset", 4, 7'd30, 1'b1, 1'b0, 32'hFFFF_FFFF, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_first_pass();
    test_bubbles();
    test_wrap();
    test_zero_rows();
    test_start_ignored();
    test_clamp();
    test_back_to_back();
    test_reset_mid_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
